// File: rtl/jtag_instruction_register.sv
// JTAG instruction register: capture/shift stage, legality-checked update stage,
// and registered one-hot decode of the current instruction.
module jtag_instruction_register #(
    parameter int unsigned          IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0]  RESET_INSTR = {IR_WIDTH{1'b1}},
    parameter int unsigned          EXTEST_OP   = 0,
    parameter int unsigned          SAMPLE_OP   = 1,
    parameter int unsigned          IDCODE_OP   = 2,
    parameter int unsigned          USER_OP     = 3
) (
    input  logic                                        TCK,
    input  logic                                        Reset,
    input  logic                                        CaptureIR,
    input  logic                                        ShiftIR,
    input  logic                                        UpdateIR,
    input  logic                                        TDI,
    input  logic [((IR_WIDTH > 2) ? IR_WIDTH - 2 : 1)-1:0] Status,
    output logic                                        TDO,
    output logic                                        TdoEn,
    output logic [IR_WIDTH-1:0]                         Q,
    output logic                                        SelExtest,
    output logic                                        SelSample,
    output logic                                        SelIdcode,
    output logic                                        SelUser,
    output logic                                        SelBypass,
    output logic                                        IllegalInstr
);

    typedef logic [IR_WIDTH-1:0] op_t;

    localparam op_t OP_EXTEST = IR_WIDTH'(EXTEST_OP);
    localparam op_t OP_SAMPLE = IR_WIDTH'(SAMPLE_OP);
    localparam op_t OP_IDCODE = IR_WIDTH'(IDCODE_OP);
    localparam op_t OP_USER   = IR_WIDTH'(USER_OP);
    localparam op_t OP_BYPASS = {IR_WIDTH{1'b1}};
    localparam op_t SR_RESET  = IR_WIDTH'(1);

    function automatic logic is_legal(input op_t op);
        return (op == OP_EXTEST) || (op == OP_SAMPLE) || (op == OP_IDCODE) ||
               (op == OP_USER)   || (op == OP_BYPASS);
    endfunction

    function automatic op_t sanitize(input op_t op);
        return is_legal(op) ? op : OP_BYPASS;
    endfunction

    // Bit order {bypass, user, idcode, sample, extest}; the if-chain resolves
    // colliding opcode parameters in favour of the earlier instruction.
    function automatic logic [4:0] decode(input op_t op);
        logic [4:0] sel;
        sel = 5'b00000;
        if (op == OP_EXTEST)      sel[0] = 1'b1;
        else if (op == OP_SAMPLE) sel[1] = 1'b1;
        else if (op == OP_IDCODE) sel[2] = 1'b1;
        else if (op == OP_USER)   sel[3] = 1'b1;
        else                      sel[4] = 1'b1;
        return sel;
    endfunction

    op_t        sr_q, sr_d;
    op_t        q_q, q_d;
    logic [4:0] sel_q, sel_d;
    logic       ill_q, ill_d;
    logic       tdoen_q;
    op_t        capture_pat;

    if (IR_WIDTH > 2) begin : g_status
        assign capture_pat = {Status, 2'b01};
    end else begin : g_no_status
        logic unused_status;
        assign unused_status = ^Status;
        assign capture_pat   = 2'b01;
    end

    always_comb begin
        sr_d = sr_q;
        if (CaptureIR) begin
            sr_d = capture_pat;
        end else if (ShiftIR) begin
            sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
        end
    end

    // The update always samples the pre-edge shift stage, even if it moves this cycle.
    always_comb begin
        q_d   = q_q;
        sel_d = sel_q;
        ill_d = ill_q;
        if (UpdateIR) begin
            q_d   = sanitize(sr_q);
            sel_d = decode(sanitize(sr_q));
            ill_d = !is_legal(sr_q);
        end
    end

    always_ff @(posedge TCK) begin
        if (Reset) begin
            sr_q    <= SR_RESET;
            q_q     <= sanitize(RESET_INSTR);
            sel_q   <= decode(sanitize(RESET_INSTR));
            ill_q   <= 1'b0;
            tdoen_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            q_q     <= q_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
            tdoen_q <= ShiftIR;
        end
    end

    assign TDO          = sr_q[0];
    assign TdoEn        = tdoen_q;
    assign Q            = q_q;
    assign SelExtest    = sel_q[0];
    assign SelSample    = sel_q[1];
    assign SelIdcode    = sel_q[2];
    assign SelUser      = sel_q[3];
    assign SelBypass    = sel_q[4];
    assign IllegalInstr = ill_q;

endmodule
